// File: rtl/feistel_round_sequencer_if.sv
// Byte/key/mode request channel and result channel of the Feistel round
// sequencer. The master side offers work and takes results; the slave side
// is the sequencer itself.
interface feistel_round_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_key;
    logic       in_decrypt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output in_valid, in_data, in_key, in_decrypt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, in_decrypt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/feistel_round_sequencer.sv
// Multi-round Feistel controller around the 8-bit nibble round function.
// A byte is accepted in IDLE, processed one round per clock in ROUND with a
// rotating key schedule, and held in DONE until the consumer takes it.
// Decrypt runs the same datapath with the encrypt key sequence reversed.
module feistel_round_sequencer #(
    parameter int ROUNDS = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    feistel_round_sequencer_if.slave    bus,
    output logic                        busy,
    output logic [3:0]                  round_idx
);

    if ((ROUNDS < 1) || (ROUNDS > 15)) begin : g_bad_rounds
        $error("feistel_round_sequencer: ROUNDS must be in 1..15");
    end

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
    // Decrypt starts from the key encrypt would use in its final round.
    localparam int         PRE_ROT    = (ROUNDS - 1) % 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Expansion, key mix, then nibble add with key[0] as carry-in.
    function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] k);
        logic [7:0] e;
        logic [7:0] x;
        e = {r[3], r[0], r[1], r[2], r[1], r[3], r[2], r[0]};
        x = e ^ k;
        return x[7:4] + x[3:0] + {3'b000, k[0]};
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] k);
        return {k[6:0], k[7]};
    endfunction

    function automatic logic [7:0] rotr1(input logic [7:0] k);
        return {k[0], k[7:1]};
    endfunction

    function automatic logic [7:0] rotl_n(input logic [7:0] k, input int n);
        logic [7:0] r;
        r = k;
        for (int i = 0; i < n; i++) begin
            r = rotl1(r);
        end
        return r;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] data_q,  data_d;
    logic [7:0] key_q,   key_d;
    logic       dec_q,   dec_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [7:0] out_q,   out_d;

    logic       last_s;
    logic [3:0] f_s;
    logic [7:0] step_s;

    // Round datapath: Feistel swap on every round except the last.
    always_comb begin
        last_s = (cnt_q == LAST_ROUND);
        f_s    = f_round(data_q[3:0], key_q);
        if (last_s) begin
            step_s = {data_q[7:4] ^ f_s, data_q[3:0]};
        end else begin
            step_s = {data_q[3:0], data_q[7:4] ^ f_s};
        end
    end

    // Next-state and register-load decode for the IDLE/ROUND/DONE sequence.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        dec_d   = dec_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    key_d   = bus.in_decrypt ? rotl_n(bus.in_key, PRE_ROT) : bus.in_key;
                    dec_d   = bus.in_decrypt;
                    cnt_d   = 4'd0;
                    state_d = ROUND;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUND: begin
                data_d = step_s;
                key_d  = dec_q ? rotr1(key_q) : rotl1(key_q);
                cnt_d  = cnt_q + 4'd1;
                if (last_s) begin
                    out_d   = step_s;
                    state_d = DONE;
                end else begin
                    state_d = ROUND;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            key_q   <= 8'h00;
            dec_q   <= 1'b0;
            cnt_q   <= 4'd0;
            out_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Status outputs decoded only from registered state.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_data  = out_q;
        busy          = (state_q == ROUND) || (state_q == DONE);
        if (state_q == ROUND) begin
            round_idx = cnt_q;
        end else begin
            round_idx = 4'd0;
        end
    end

endmodule

// File: doc/feistel_round_sequencer.md
Name: feistel_round_sequencer

Overview:
- Multi-round controller for the 8-bit nibble round function used by the encryption datapath: expansion box, 8-bit key XOR, nibble add with key[0] carry-in, and high-nibble XOR.
- Accepts a byte, key and direction through a valid/ready handshake, iterates the round function ROUNDS times with a rotating key schedule, and presents the result through a valid/ready output.
- Sits between the byte source and the downstream consumer. With ROUNDS=1 the encrypt result is bit-identical to the existing single-round encrypt path.

Parameters:
ROUNDS, 4, number of rounds per operation; legal range 1..15, out-of-range is an elaboration error

Ports:
clock      input   1  system clock, all state updates on rising edge
reset      input   1  asynchronous, active-low; 0 forces all state to reset values immediately
in_valid   input   1  input byte/key/mode offered
in_ready   output  1  block can accept; high only in IDLE
in_data    input   8  plaintext (encrypt) or ciphertext (decrypt); [7:4]=L, [3:0]=R
in_key     input   8  master key
in_decrypt input   1  0=encrypt, 1=decrypt; sampled at accept
out_valid  output  1  result available; high only in DONE
out_ready  input   1  consumer accepts result
out_data   output  8  result byte
busy       output  1  high in ROUND or DONE
round_idx  output  4  index of the round executing this cycle (0..ROUNDS-1); 0 outside ROUND

Behaviour:
- Reset (reset=0, async): state=IDLE, data/key/mode registers=0, round counter=0, out_data=0x00, out_valid=0, busy=0, round_idx=0, in_ready=1.
- Round function F(R,K), combinational, 4-bit result:
  - E = {R[3],R[0],R[1],R[2],R[1],R[3],R[2],R[0]}.
  - X = E ^ K.
  - F = (X[7:4] + X[3:0] + K[0]) mod 16; carry-out discarded.
- Round step on state {L,R} with round key k:
  - Not last round: next = {R, L^F(R,k)} (Feistel swap).
  - Last round: next = {L^F(R,k), R} (no swap).
- Key schedule, with rotl = rotate left by 1 and rotr = rotate right by 1:
  - Encrypt: k_0 = in_key, k_{i+1} = rotl(k_i).
  - Decrypt: k_0 = in_key rotated left by ROUNDS-1, k_{i+1} = rotr(k_i). This is the encrypt key sequence reversed, so decrypt(encrypt(x,key),key)=x for every ROUNDS.
- FSM states IDLE, ROUND, DONE:
  - IDLE: in_ready=1. On edge with in_valid=1, capture in_data, in_key (pre-rotated if decrypt) and in_decrypt, clear the counter and go to ROUND. in_valid=0 stays in IDLE.
  - ROUND: one round per clock. The data register takes the round step, the key register steps per schedule, and the counter increments. The edge completing round ROUNDS-1 loads out_data with the final value and goes to DONE.
  - DONE: out_valid=1 and out_data stable. On edge with out_ready=1, go to IDLE; out_data holds its last value. out_ready=0 holds DONE indefinitely.
- Latency: accepted at edge t, out_valid rises after edge t+ROUNDS. Minimum accept-to-accept interval is ROUNDS+2 cycles; there is no back-to-back accept from DONE.
- in_valid outside IDLE is ignored, and in_data/in_key/in_decrypt changes outside IDLE have no effect.
- out_ready outside DONE is ignored.
- reset asserted mid-ROUND or mid-DONE aborts the operation, returns to reset values and produces no output. The first accept is possible on the first rising edge after deassertion.
- in_ready, out_valid, busy and round_idx are decoded from registered state only, with no combinational path from inputs.

Test Plan:
- ROUNDS=1, encrypt in_data=0x46, in_key=0x93 -> E=0x3A, X=0xA9, F=0x4; out_data=0x06, out_valid one cycle after accept.
- ROUNDS=1, encrypt 0xC9 with key 0xAC -> out_data=0x39. Then decrypt 0x39 with key 0xAC -> 0xC9. Also decrypt 0x06 with key 0x93 -> 0x46.
- ROUNDS=4, all 256 data values x keys {0x00,0x5A,0xB1,0xFF}: encrypt then decrypt returns the original. out_valid rises exactly 4 edges after each accept. round_idx steps 0,1,2,3. Each result matches the reference-model sequence.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, and an in_valid pulse with 0xFF is not captured. Release out_ready -> IDLE next edge, in_ready=1.
- Reset mid-operation: ROUNDS=4, drop reset after round_idx=2 -> outputs immediately reset values (out_data=0x00, busy=0, in_ready=1). A new accept of 0x46/0x93 after release completes normally.
- Mode sampling: accept encrypt, then toggle in_decrypt and in_key during ROUND -> result equals pure encrypt with the original key.
